// File: rtl/pkt_frame_uploader_pkg.sv
// Shared definitions for the packet frame uploader: FSM state encoding,
// preamble/marker byte values and the FIFO pointer-width helper.
package pkt_upl_pkg;

   // Bit positions of the one-hot state vector
   typedef enum logic [2:0] {
      IDX_IDLE = 3'd0,
      IDX_SYNC = 3'd1,
      IDX_LOAD = 3'd2,
      IDX_MARK = 3'd3,
      IDX_SEND = 3'd4
   } stateIdx_t;

   localparam logic [4:0] IDLE = 5'b00001;
   localparam logic [4:0] SYNC = 5'b00010;
   localparam logic [4:0] LOAD = 5'b00100;
   localparam logic [4:0] MARK = 5'b01000;
   localparam logic [4:0] SEND = 5'b10000;

   localparam logic [7:0] SYNC_FILL = 8'hFF;
   localparam logic [7:0] SYNC_LAST = 8'h7F;
   localparam logic [7:0] OVF_MARK  = 8'hA5;

   // FIFO pointers are exactly DEPTH_LOG2 wide so they wrap for free
   function automatic int ptrWidth(input int depthLog2);
      return (depthLog2 < 1) ? 1 : depthLog2;
   endfunction

endpackage

// File: rtl/pkt_frame_uploader_if.sv
// Byte stream towards the host link: valid/ready handshake, one byte per transfer.
interface pkt_frame_uploader_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/pkt_frame_uploader_fifo.sv
// Packet FIFO: dual-port RAM plus write/read pointers, full detection,
// drop reporting and fill level. Read data has one cycle of latency.
module pkt_fifo
   import pkt_upl_pkg::*;
#(
   parameter int WIDTH      = 128,
   parameter int DEPTH_LOG2 = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_stb,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_adv,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  empty,
   output logic                  drop,
   output logic                  overflow,
   output logic [DEPTH_LOG2-1:0] fill
);
   localparam int PW = ptrWidth(DEPTH_LOG2);

   logic [WIDTH-1:0] mem [0:(1<<PW)-1];
   logic [PW-1:0]    wp;
   logic [PW-1:0]    rp;
   logic [PW-1:0]    wpNext;
   logic             full;

   // One slot is sacrificed so full and empty stay distinguishable
   assign wpNext = wp + 1'b1;
   assign full   = (wpNext == rp);
   assign empty  = (wp == rp);
   assign drop   = wr_stb && full;
   assign fill   = wp - rp;

   // Pointer update and one-cycle overflow pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp       <= '0;
         rp       <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= drop;
         if (wr_stb && !full) wp <= wpNext;
         if (rd_adv)          rp <= rp + 1'b1;
      end
   end

   // RAM write port; contents need no reset since the pointers define validity
   always_ff @(posedge clk) begin
      if (wr_stb && !full) mem[wp] <= wr_data;
   end

   // Registered read of the head entry
   always_ff @(posedge clk) begin
      rd_data <= mem[rp];
   end

endmodule

// File: rtl/pkt_frame_uploader.sv
// Packet buffer and byte serialiser between the packet finder and the host link.
// Packets arrive on pk_toggle edges, are queued in pkt_fifo and sent LSB first
// over a valid/ready byte stream, with a sync preamble every SYNC_INTERVAL frames.
// Optional feature macro: OVF_MARKER_EN (adds an A5+count drop marker before a frame).
//
// state | meaning
// IDLE  | waiting for a queued packet
// SYNC  | sending preamble FF..FF,7F
// LOAD  | head packet read from RAM into the shift register
// MARK  | sending A5 and the latched drop count (OVF_MARKER_EN only)
// SEND  | sending packet bytes, LSB first
module pkt_frame_uploader
   import pkt_upl_pkg::*;
#(
   parameter int PKT_BYTES     = 16,
   parameter int DEPTH_LOG2    = 9,
   parameter int SYNC_BYTES    = 4,
   parameter int SYNC_INTERVAL = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pk_toggle,
   input  logic [8*PKT_BYTES-1:0] packet,
   pkt_frame_uploader_if.master   host,
   output logic                   overflow,
   output logic [DEPTH_LOG2-1:0]  fill
);
   localparam int PKT_W     = 8*PKT_BYTES;
   localparam int MAX_BYTES = (PKT_BYTES > SYNC_BYTES) ? PKT_BYTES : SYNC_BYTES;
   localparam int CNT_W     = $clog2(MAX_BYTES + 1);
   localparam int SC_W      = (SYNC_INTERVAL > 1) ? $clog2(SYNC_INTERVAL) : 1;

   logic [2:0]       togSync;
   logic             wrStb;
   logic [PKT_W-1:0] rdData;
   logic             empty;
   logic             rdAdv;
   logic             xfer;
   logic [4:0]       state;
   logic [CNT_W-1:0] byteCnt;
   logic [PKT_W-1:0] shiftReg;
   logic [SC_W-1:0]  syncCnt;
   logic [SC_W-1:0]  syncNext;
`ifdef OVF_MARKER_EN
   logic             drop;
   logic [7:0]       dropCnt;
   logic [7:0]       markVal;
`else
   logic             unusedDrop;
`endif

   // Synchronise the asynchronous toggle; any edge yields a one-cycle strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) togSync <= '0;
      else     togSync <= {togSync[1:0], pk_toggle};
   end

   assign wrStb = togSync[2] ^ togSync[1];

   pkt_fifo #(
      .WIDTH      (PKT_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) uFifo (
      .clk      (clk),
      .rst      (rst),
      .wr_stb   (wrStb),
      .wr_data  (packet),
      .rd_adv   (rdAdv),
      .rd_data  (rdData),
      .empty    (empty),
`ifdef OVF_MARKER_EN
      .drop     (drop),
`else
      .drop     (unusedDrop),
`endif
      .overflow (overflow),
      .fill     (fill)
   );

   assign xfer     = host.out_valid && host.out_ready;
   assign rdAdv    = state[IDX_SEND] && xfer && (byteCnt == '0);
   assign syncNext = (syncCnt == SC_W'(SYNC_INTERVAL - 1)) ? '0 : syncCnt + 1'b1;

`ifdef OVF_MARKER_EN
   // Saturating drop counter; LOAD hands its value to the marker and restarts it
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             dropCnt <= '0;
      else if (state[IDX_LOAD])            dropCnt <= {7'd0, drop};
      else if (drop && dropCnt != 8'hFF)   dropCnt <= dropCnt + 1'b1;
   end
`endif

   // Frame sequencer and byte serialiser; out_data only moves on a transfer or while invalid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         host.out_valid <= 1'b0;
         host.out_data  <= '0;
         byteCnt        <= '0;
         shiftReg       <= '0;
         syncCnt        <= '0;
`ifdef OVF_MARKER_EN
         markVal        <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  if (syncCnt == '0) begin
                     state          <= SYNC;
                     host.out_valid <= 1'b1;
                     host.out_data  <= (SYNC_BYTES == 1) ? SYNC_LAST : SYNC_FILL;
                     byteCnt        <= CNT_W'(SYNC_BYTES - 1);
                  end else begin
                     state <= LOAD;
                  end
               end
            end
            SYNC: begin
               if (xfer) begin
                  if (byteCnt == '0) begin
                     state          <= LOAD;
                     host.out_valid <= 1'b0;
                  end else begin
                     byteCnt       <= byteCnt - 1'b1;
                     host.out_data <= (byteCnt == CNT_W'(1)) ? SYNC_LAST : SYNC_FILL;
                  end
               end
            end
            LOAD: begin
`ifdef OVF_MARKER_EN
               if (dropCnt != '0) begin
                  state          <= MARK;
                  host.out_valid <= 1'b1;
                  host.out_data  <= OVF_MARK;
                  markVal        <= dropCnt;
                  shiftReg       <= rdData;
                  byteCnt        <= CNT_W'(1);
               end else
`endif
               begin
                  state          <= SEND;
                  host.out_valid <= 1'b1;
                  host.out_data  <= rdData[7:0];
                  shiftReg       <= rdData >> 8;
                  byteCnt        <= CNT_W'(PKT_BYTES - 1);
               end
            end
`ifdef OVF_MARKER_EN
            MARK: begin
               if (xfer) begin
                  if (byteCnt == '0) begin
                     state         <= SEND;
                     host.out_data <= shiftReg[7:0];
                     shiftReg      <= shiftReg >> 8;
                     byteCnt       <= CNT_W'(PKT_BYTES - 1);
                  end else begin
                     host.out_data <= markVal;
                     byteCnt       <= '0;
                  end
               end
            end
`endif
            SEND: begin
               if (xfer) begin
                  if (byteCnt == '0) begin
                     state          <= IDLE;
                     host.out_valid <= 1'b0;
                     syncCnt        <= syncNext;
                  end else begin
                     host.out_data <= shiftReg[7:0];
                     shiftReg      <= shiftReg >> 8;
                     byteCnt       <= byteCnt - 1'b1;
                  end
               end
            end
            default: begin
               state          <= IDLE;
               host.out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
